decay_timestep_ctrl: RTL and testbench
======================================

DECAY_TIMESTEP_CTRL -- requirements
Module: decay_timestep_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 2: number of cycles clear_decay is held high per timestep (legal range 1..15).
REQ-002 SHALL have parameter NUM_TIMESTEPS, default 16: timesteps per run (legal range 1..65535).
REQ-003 SHALL have parameter INIT_POTENTIAL, default 32'h41DED852: IEEE-754 single value the decay block loads on set.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: run request, sampled in IDLE only.
REQ-007 SHALL have port stop, input, 1 bit: abort request; the run ends after the current timestep.
REQ-008 SHALL have port spike_valid, input, 1 bit: spike_potential is valid this cycle.
REQ-009 SHALL have port spike_potential, input, 32 bits: potential value from the adder side.
REQ-010 SHALL have port decayed_potential, input, 32 bits: the decay block's output potential.
REQ-011 SHALL have port set_decay, output, 1 bit: initialisation strobe to the decay block.
REQ-012 SHALL have port clear_decay, output, 1 bit: per-timestep decay strobe.
REQ-013 SHALL have port new_potential, output, 32 bits: potential presented to the decay block.
REQ-014 SHALL have port potential_out, output, 32 bits: last captured decayed potential.
REQ-015 SHALL have port potential_valid, output, 1 bit: one-cycle pulse when potential_out updates.
REQ-016 SHALL have port timestep_count, output, 16 bits: number of completed timesteps in the current run.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-019 SHALL implement a state machine with states IDLE, INIT, LOAD, CLEAR, CAPTURE and DONE. All outputs SHALL be registered.
REQ-020 State transitions:
- IDLE to INIT when start=1.
- INIT to LOAD after 1 cycle.
- LOAD to CLEAR after 1 cycle.
- CLEAR to CAPTURE after CLEAR_CYCLES cycles.
- CAPTURE to LOAD, or to DONE when (timestep_count+1)==NUM_TIMESTEPS or stop is pending.
- DONE to IDLE after 1 cycle.
REQ-021 In INIT, set_decay SHALL be 1 for exactly one cycle, the internal potential register SHALL load INIT_POTENTIAL, timestep_count SHALL clear to 0, and the pending-spike and pending-stop flags SHALL clear.
REQ-022 set_decay and clear_decay SHALL never be high in the same cycle. clear_decay SHALL be high exactly in CLEAR cycles.
REQ-023 Selection of new_potential in LOAD, in priority order:
- spike_potential, if spike_valid=1 in that cycle;
- otherwise the latched pending spike, if one exists;
- otherwise the internal potential register.
The pending flag SHALL clear in LOAD.
REQ-024 new_potential SHALL hold its LOAD value unchanged through CLEAR and CAPTURE.
REQ-025 spike_valid in INIT, CLEAR or CAPTURE SHALL latch spike_potential as pending; the last value before LOAD wins. spike_valid in IDLE or DONE SHALL be ignored.
REQ-026 In CAPTURE, the block SHALL:
- sample decayed_potential into potential_out and the internal potential register;
- pulse potential_valid;
- increment timestep_count.
REQ-027 Latency from start=1 in IDLE to the first potential_valid SHALL be 3+CLEAR_CYCLES cycles; timestep period SHALL be CLEAR_CYCLES+2 cycles.
REQ-028 stop=1 in any busy state other than DONE SHALL set a pending-stop flag. The current timestep SHALL complete, including its capture, before DONE. stop in IDLE SHALL be ignored.
REQ-029 start asserted while busy SHALL be ignored. start and stop both high in IDLE SHALL start a run that stops after its first timestep.
REQ-030 done SHALL pulse for one cycle in DONE. timestep_count and potential_out SHALL hold their values through IDLE until the next INIT.
REQ-031 The block SHALL perform no floating-point arithmetic: potentials are moved as opaque 32-bit values.

Reset
REQ-032 reset=1 SHALL immediately force the following, including mid-timestep:
- state to IDLE;
- set_decay, clear_decay, potential_valid, done and busy to 0;
- new_potential, potential_out and timestep_count to 0;
- internal potential register to INIT_POTENTIAL;
- pending flags cleared.
REQ-033 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 Basic run: CLEAR_CYCLES=2, NUM_TIMESTEPS=3, start pulse, decay model returns input/2 -> set_decay one cycle; new_potential=41DED852 in first LOAD; potential_valid at cycle 5 after start; three captures with period 4; done pulse; timestep_count=3.
REQ-035 Spike injection: spike_valid with 3F800000 during CLEAR of timestep 1 -> new_potential=3F800000 in LOAD of timestep 2; a second spike 40000000 in the same window replaces it.
REQ-036 Early stop: NUM_TIMESTEPS=16, stop pulse during CLEAR of timestep 2 -> timestep 2 capture completes; done follows; timestep_count=2.
REQ-037 Reset mid-CLEAR: reset during clear_decay=1 -> clear_decay=0 immediately with no clock; outputs zero; a subsequent start reloads 41DED852.
REQ-038 Protocol checks over all runs: set_decay and clear_decay never both high; clear_decay is high exactly CLEAR_CYCLES consecutive cycles per timestep; start during busy has no effect.

Source files
------------

// File: rtl/decay_timestep_ctrl.sv
// Sequences a leaky-decay block: set once per run, then LOAD/CLEAR/CAPTURE per timestep.
// Latency: first potential_valid 3+CLEAR_CYCLES cycles after start; one capture every CLEAR_CYCLES+2.
// Backpressure: none; start is ignored while busy, stop ends the run after the current timestep.
module decay_timestep_ctrl #(
    parameter int          CLEAR_CYCLES   = 2,
    parameter int          NUM_TIMESTEPS  = 16,
    parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        spike_valid,
    input  logic [31:0] spike_potential,
    input  logic [31:0] decayed_potential,
    output logic        set_decay,
    output logic        clear_decay,
    output logic [31:0] new_potential,
    output logic [31:0] potential_out,
    output logic        potential_valid,
    output logic [15:0] timestep_count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        LOAD    = 3'd2,
        CLEAR   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [3:0]  CLR_LAST = 4'(CLEAR_CYCLES - 1);
    localparam logic [15:0] NUM_TS   = 16'(NUM_TIMESTEPS);

    state_t      state_q, state_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic        spk_pend_q, spk_pend_d;
    logic [31:0] spk_dat_q, spk_dat_d;
    logic        stop_pend_q, stop_pend_d;
    logic [31:0] pot_q, pot_d;
    logic [31:0] new_potential_d, potential_out_d;
    logic [15:0] timestep_count_d;
    logic        in_run;

    // Every output is registered and derived from the next state, so each
    // strobe is high exactly during the state it belongs to.
    always_comb begin
        state_d          = state_q;
        clr_cnt_d        = clr_cnt_q;
        spk_pend_d       = spk_pend_q;
        spk_dat_d        = spk_dat_q;
        stop_pend_d      = stop_pend_q;
        pot_d            = pot_q;
        new_potential_d  = new_potential;
        potential_out_d  = potential_out;
        timestep_count_d = timestep_count;

        in_run = (state_q != IDLE) && (state_q != DONE);
        if (in_run && spike_valid) begin
            spk_pend_d = 1'b1;
            spk_dat_d  = spike_potential;
        end
        if (in_run && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d          = INIT;
                    pot_d            = INIT_POTENTIAL;
                    timestep_count_d = 16'd0;
                    spk_pend_d       = 1'b0;
                    // start and stop together still yield one full timestep
                    stop_pend_d      = stop;
                end
            end
            INIT: state_d = LOAD;
            LOAD: begin
                state_d   = CLEAR;
                clr_cnt_d = 4'd0;
            end
            CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d          = CAPTURE;
                    potential_out_d  = decayed_potential;
                    pot_d            = decayed_potential;
                    timestep_count_d = timestep_count + 16'd1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 4'd1;
                end
            end
            CAPTURE: begin
                if ((timestep_count == NUM_TS) || stop_pend_q || stop) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The LOAD selection is made on the edge into LOAD; a spike seen during
        // LOAD itself stays pending for the following timestep.
        if (state_d == LOAD) begin
            if (spike_valid) begin
                new_potential_d = spike_potential;
            end else if (spk_pend_q) begin
                new_potential_d = spk_dat_q;
            end else begin
                new_potential_d = pot_q;
            end
            spk_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            clr_cnt_q       <= 4'd0;
            spk_pend_q      <= 1'b0;
            spk_dat_q       <= 32'd0;
            stop_pend_q     <= 1'b0;
            pot_q           <= INIT_POTENTIAL;
            new_potential   <= 32'd0;
            potential_out   <= 32'd0;
            timestep_count  <= 16'd0;
            set_decay       <= 1'b0;
            clear_decay     <= 1'b0;
            potential_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            spk_pend_q      <= spk_pend_d;
            spk_dat_q       <= spk_dat_d;
            stop_pend_q     <= stop_pend_d;
            pot_q           <= pot_d;
            new_potential   <= new_potential_d;
            potential_out   <= potential_out_d;
            timestep_count  <= timestep_count_d;
            set_decay       <= (state_d == INIT);
            clear_decay     <= (state_d == CLEAR);
            potential_valid <= (state_d == CAPTURE);
            busy            <= (state_d != IDLE);
            done            <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_decay_timestep_ctrl.sv
// Directed bench for decay_timestep_ctrl; the decay block is modelled as a float halving
// (exponent minus one). Captures and done pulses are checked by a queue-driven monitor.
module tb_decay_timestep_ctrl;

    localparam int CC = 2;
    localparam int NT = 3;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        stop;
    logic        spike_valid;
    logic [31:0] spike_potential;
    logic [31:0] decayed_potential;
    logic        set_decay;
    logic        clear_decay;
    logic [31:0] new_potential;
    logic [31:0] potential_out;
    logic        potential_valid;
    logic [15:0] timestep_count;
    logic        busy;
    logic        done;

    decay_timestep_ctrl #(
        .CLEAR_CYCLES   (CC),
        .NUM_TIMESTEPS  (NT),
        .INIT_POTENTIAL (32'h41DED852)
    ) dut (
        .CLK               (CLK),
        .reset             (reset),
        .start             (start),
        .stop              (stop),
        .spike_valid       (spike_valid),
        .spike_potential   (spike_potential),
        .decayed_potential (decayed_potential),
        .set_decay         (set_decay),
        .clear_decay       (clear_decay),
        .new_potential     (new_potential),
        .potential_out     (potential_out),
        .potential_valid   (potential_valid),
        .timestep_count    (timestep_count),
        .busy              (busy),
        .done              (done)
    );

    // halving an IEEE single: decrement the exponent field
    assign decayed_potential = new_potential - 32'h0080_0000;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_done;
        logic [31:0] np;
        logic [31:0] po;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_vec;
    int   n_bad;
    int   clr_run;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_cap(input int c, input logic [31:0] np, input logic [31:0] po,
                            input logic [15:0] cnt);
        exp_t e;
        e.is_done = 1'b0; e.np = np; e.po = po; e.cnt = cnt; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c, input logic [31:0] po, input logic [15:0] cnt);
        exp_t e;
        e.is_done = 1'b1; e.np = 32'd0; e.po = po; e.cnt = cnt; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per potential_valid or done pulse.
    always @(negedge CLK) begin
        if (reset) begin
            clr_run = 0;
        end else begin
            if (set_decay || clear_decay) chk("set_clear_overlap", {31'd0, set_decay && clear_decay}, 32'd0);
            if (clear_decay) begin
                clr_run++;
            end else if (clr_run != 0) begin
                chk("clear_run_length", clr_run, CC);
                clr_run = 0;
            end
            if (potential_valid || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, potential_valid, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pulse_kind", {31'd0, done}, {31'd0, e.is_done});
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("potential_out", potential_out, e.po);
                    chk("timestep_count", {16'd0, timestep_count}, {16'd0, e.cnt});
                    if (!e.is_done) chk("new_potential", new_potential, e.np);
                end
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start_run(input logic with_stop, output int s);
        @(posedge CLK);
        #1;
        start = 1'b1;
        stop  = with_stop;
        s     = cyc;
        @(posedge CLK);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 200;
        while ((exp_q.size() != 0 || busy) && budget > 0) begin
            @(posedge CLK);
            #1;
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s drain timeout: %0d expectations left, busy=%0b", name, exp_q.size(), busy);
            exp_q.delete();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    // Expectations for an undisturbed run starting at cycle s from INIT_POTENTIAL.
    task automatic push_plain(input int s);
        push_cap(s + 5,  32'h41DED852, 32'h415ED852, 16'd1);
        push_cap(s + 9,  32'h415ED852, 32'h40DED852, 16'd2);
        push_cap(s + 13, 32'h40DED852, 32'h405ED852, 16'd3);
        push_done(s + 14, 32'h405ED852, 16'd3);
    endtask

    initial begin
        int s;
        cyc = 0; n_vec = 0; n_bad = 0; clr_run = 0;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        spike_valid = 1'b0; spike_potential = 32'd0;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_new_potential", new_potential, 32'd0);
        chk("reset_potential_out", potential_out, 32'd0);
        chk("reset_count", {16'd0, timestep_count}, 32'd0);
        chk("reset_strobes", {28'd0, set_decay, clear_decay, potential_valid, done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_wait", {31'd0, busy}, 32'd0);

        // basic run with an ignored start while busy
        start_run(1'b0, s);
        push_plain(s);
        chk("init_set_decay", {31'd0, set_decay}, 32'd1);
        chk("init_busy", {31'd0, busy}, 32'd1);
        wait_to(s + 2);
        chk("load_set_decay_off", {31'd0, set_decay}, 32'd0);
        chk("first_load_potential", new_potential, 32'h41DED852);
        wait_to(s + 7);
        start = 1'b1;
        wait_to(s + 8);
        start = 1'b0;
        drain("basic");
        chk("hold_count", {16'd0, timestep_count}, 32'd3);
        chk("hold_potential_out", potential_out, 32'h405ED852);

        // single spike in CLEAR of timestep 1; a spike in IDLE alongside start is dropped
        @(posedge CLK);
        #1;
        spike_valid = 1'b1; spike_potential = 32'h12345678;
        start_run(1'b0, s);
        spike_valid = 1'b0;
        push_cap(s + 5,  32'h41DED852, 32'h415ED852, 16'd1);
        push_cap(s + 9,  32'h3F800000, 32'h3F000000, 16'd2);
        push_cap(s + 13, 32'h3F000000, 32'h3E800000, 16'd3);
        push_done(s + 14, 32'h3E800000, 16'd3);
        wait_to(s + 3);
        spike_valid = 1'b1; spike_potential = 32'h3F800000;
        wait_to(s + 4);
        spike_valid = 1'b0;
        drain("spike_single");

        // two spikes in the same window: the later one wins
        start_run(1'b0, s);
        push_cap(s + 5,  32'h41DED852, 32'h415ED852, 16'd1);
        push_cap(s + 9,  32'h40000000, 32'h3F800000, 16'd2);
        push_cap(s + 13, 32'h3F800000, 32'h3F000000, 16'd3);
        push_done(s + 14, 32'h3F000000, 16'd3);
        wait_to(s + 3);
        spike_valid = 1'b1; spike_potential = 32'h3F800000;
        wait_to(s + 4);
        spike_potential = 32'h40000000;
        wait_to(s + 5);
        spike_valid = 1'b0;
        drain("spike_double");

        // stop during CLEAR of timestep 2
        start_run(1'b0, s);
        push_cap(s + 5,  32'h41DED852, 32'h415ED852, 16'd1);
        push_cap(s + 9,  32'h415ED852, 32'h40DED852, 16'd2);
        push_done(s + 10, 32'h40DED852, 16'd2);
        wait_to(s + 7);
        stop = 1'b1;
        wait_to(s + 8);
        stop = 1'b0;
        drain("early_stop");
        chk("early_stop_count", {16'd0, timestep_count}, 32'd2);

        // start and stop together: one timestep only
        start_run(1'b1, s);
        push_cap(s + 5, 32'h41DED852, 32'h415ED852, 16'd1);
        push_done(s + 6, 32'h415ED852, 16'd1);
        drain("start_stop");

        // asynchronous reset in the middle of CLEAR
        start_run(1'b0, s);
        wait_to(s + 3);
        chk("pre_reset_clear", {31'd0, clear_decay}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_clear", {31'd0, clear_decay}, 32'd0);
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_outputs", new_potential | potential_out, 32'd0);
        chk("async_reset_count", {16'd0, timestep_count}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;

        // stop in IDLE is ignored, then a full run reloads the initial potential
        stop = 1'b1;
        @(posedge CLK);
        #1;
        stop = 1'b0;
        start_run(1'b0, s);
        push_plain(s);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
